// File: rtl/mips_mc_cpu.sv
// Multi-cycle MIPS subset core. It has one FSM state per clock and valid/ack handshakes on the
// fetch, memory-request and read-data channels. Request strobes are registered from the next state.
module mips_mc_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          PERF_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ack,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Ack,
    output logic [31:0] Address,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [31:0] Write_data,
    input  logic        Mem_Req_Ack,
    input  logic [31:0] Read_data,
    input  logic        Read_data_Valid,
    output logic        Read_data_Ack,
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt
);

    typedef enum logic [2:0] {S_IF, S_IW, S_ID, S_EX, S_ST, S_LD, S_RDW, S_WB} state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, ir_r, a_r, b_r, alu_r, addr_r, wdata_r;
    logic [4:0]  dest_r;
    logic [31:0] rf_r [32];
    logic        inst_req_valid_r, inst_ack_r, mem_write_r, mem_read_r, rd_ack_r;
    logic [31:0] cyc_r, icnt_r;

    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, shamt_s, dest_s, rf_wa_s;
    logic [15:0] imm_s;
    logic [31:0] simm_s, zimm_s, pc4_s, br_tgt_s, jmp_tgt_s, ex_pc_s, pc_ret_s;
    logic [31:0] alu_res_s, rf_wd_s;
    logic        wb_en_s, is_lw_s, is_sw_s, retire_s, rf_we_s;

    assign opcode_s  = ir_r[31:26];
    assign rs_s      = ir_r[25:21];
    assign rt_s      = ir_r[20:16];
    assign rd_s      = ir_r[15:11];
    assign shamt_s   = ir_r[10:6];
    assign funct_s   = ir_r[5:0];
    assign imm_s     = ir_r[15:0];
    assign simm_s    = {{16{imm_s[15]}}, imm_s};
    assign zimm_s    = {16'h0000, imm_s};
    assign pc4_s     = pc_r + 32'd4;
    assign br_tgt_s  = pc4_s + {simm_s[29:0], 2'b00};
    assign jmp_tgt_s = {pc4_s[31:28], ir_r[25:0], 2'b00};

    // Execute decode: ALU result, writeback target and next PC for instructions retiring in EX
    always_comb begin
        alu_res_s = 32'h0000_0000;
        wb_en_s   = 1'b0;
        dest_s    = rt_s;
        is_lw_s   = 1'b0;
        is_sw_s   = 1'b0;
        ex_pc_s   = pc4_s;
        case (opcode_s)
            6'h00: begin
                dest_s  = rd_s;
                wb_en_s = 1'b1;
                case (funct_s)
                    6'h21:   alu_res_s = a_r + b_r;
                    6'h23:   alu_res_s = a_r - b_r;
                    6'h24:   alu_res_s = a_r & b_r;
                    6'h25:   alu_res_s = a_r | b_r;
                    6'h26:   alu_res_s = a_r ^ b_r;
                    6'h27:   alu_res_s = ~(a_r | b_r);
                    6'h2A:   alu_res_s = {31'h0, ($signed(a_r) < $signed(b_r))};
                    6'h2B:   alu_res_s = {31'h0, (a_r < b_r)};
                    6'h00:   alu_res_s = b_r << shamt_s;
                    6'h02:   alu_res_s = b_r >> shamt_s;
                    default: wb_en_s   = 1'b0;
                endcase
            end
            6'h09: begin alu_res_s = a_r + simm_s; wb_en_s = 1'b1; end
            6'h0A: begin alu_res_s = {31'h0, ($signed(a_r) < $signed(simm_s))}; wb_en_s = 1'b1; end
            6'h0C: begin alu_res_s = a_r & zimm_s; wb_en_s = 1'b1; end
            6'h0D: begin alu_res_s = a_r | zimm_s; wb_en_s = 1'b1; end
            6'h0F: begin alu_res_s = {imm_s, 16'h0000}; wb_en_s = 1'b1; end
            6'h23: is_lw_s = 1'b1;
            6'h2B: is_sw_s = 1'b1;
            6'h04: begin
                if (a_r == b_r) ex_pc_s = br_tgt_s;
                else            ex_pc_s = pc4_s;
            end
            6'h05: begin
                if (a_r != b_r) ex_pc_s = br_tgt_s;
                else            ex_pc_s = pc4_s;
            end
            6'h02:   ex_pc_s = jmp_tgt_s;
            default: wb_en_s = 1'b0;
        endcase
    end

    // Next-state logic and retire detection
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        pc_ret_s    = pc4_s;
        case (state_r)
            S_IF: begin
                if (inst_req_valid_r && Inst_Req_Ack) state_nxt_s = S_IW;
                else                                  state_nxt_s = S_IF;
            end
            S_IW: begin
                if (inst_ack_r && Inst_Valid) state_nxt_s = S_ID;
                else                          state_nxt_s = S_IW;
            end
            S_ID: state_nxt_s = S_EX;
            S_EX: begin
                if (is_lw_s)      state_nxt_s = S_LD;
                else if (is_sw_s) state_nxt_s = S_ST;
                else if (wb_en_s) state_nxt_s = S_WB;
                else begin
                    state_nxt_s = S_IF;
                    retire_s    = 1'b1;
                    pc_ret_s    = ex_pc_s;
                end
            end
            S_ST: begin
                if (Mem_Req_Ack) begin
                    state_nxt_s = S_IF;
                    retire_s    = 1'b1;
                end else begin
                    state_nxt_s = S_ST;
                end
            end
            S_LD: begin
                if (Mem_Req_Ack) state_nxt_s = S_RDW;
                else             state_nxt_s = S_LD;
            end
            S_RDW: begin
                if (Read_data_Valid) begin
                    state_nxt_s = S_IF;
                    retire_s    = 1'b1;
                end else begin
                    state_nxt_s = S_RDW;
                end
            end
            S_WB: begin
                state_nxt_s = S_IF;
                retire_s    = 1'b1;
            end
            default: state_nxt_s = S_IF;
        endcase
    end

    // Register-file write port: ALU result in WB, load data when it arrives in RDW
    always_comb begin
        rf_we_s = 1'b0;
        rf_wa_s = dest_r;
        rf_wd_s = alu_r;
        if (state_r == S_WB) begin
            rf_we_s = 1'b1;
        end else if ((state_r == S_RDW) && Read_data_Valid) begin
            rf_we_s = 1'b1;
            rf_wd_s = Read_data;
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // State, PC and handshake strobes; the strobes follow the next state so they are glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= S_IF;
            pc_r             <= RESET_PC;
            inst_req_valid_r <= 1'b0;
            inst_ack_r       <= 1'b0;
            mem_write_r      <= 1'b0;
            mem_read_r       <= 1'b0;
            rd_ack_r         <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            inst_req_valid_r <= (state_nxt_s == S_IF);
            inst_ack_r       <= (state_nxt_s == S_IW);
            mem_write_r      <= (state_nxt_s == S_ST);
            mem_read_r       <= (state_nxt_s == S_LD);
            rd_ack_r         <= (state_nxt_s == S_RDW);
            if (retire_s) pc_r <= pc_ret_s;
            else          pc_r <= pc_r;
        end
    end

    // Datapath latches: IR, operands, and the EX results that stay stable through ST/LD/RDW/WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_r    <= 32'h0000_0000;
            a_r     <= 32'h0000_0000;
            b_r     <= 32'h0000_0000;
            alu_r   <= 32'h0000_0000;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            dest_r  <= 5'd0;
        end else begin
            if ((state_r == S_IW) && Inst_Valid) ir_r <= Instruction;
            if (state_r == S_ID) begin
                a_r <= rf_r[rs_s];
                b_r <= rf_r[rt_s];
            end
            if (state_r == S_EX) begin
                alu_r   <= alu_res_s;
                dest_r  <= dest_s;
                addr_r  <= a_r + simm_s;
                wdata_r <= b_r;
            end
        end
    end

    // Register file; $0 is never written so it always reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_r[i] <= 32'h0000_0000;
        end else begin
            if (rf_we_s && (rf_wa_s != 5'd0)) rf_r[rf_wa_s] <= rf_wd_s;
        end
    end

    // Performance counters, held at zero when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_r  <= 32'h0000_0000;
            icnt_r <= 32'h0000_0000;
        end else if (PERF_EN) begin
            cyc_r <= cyc_r + 32'd1;
            if (retire_s) icnt_r <= icnt_r + 32'd1;
            else          icnt_r <= icnt_r;
        end else begin
            cyc_r  <= 32'h0000_0000;
            icnt_r <= 32'h0000_0000;
        end
    end

    assign PC             = pc_r;
    assign Inst_Req_Valid = inst_req_valid_r;
    assign Inst_Ack       = inst_ack_r;
    assign Address        = addr_r;
    assign MemWrite       = mem_write_r;
    assign MemRead        = mem_read_r;
    assign Write_data     = wdata_r;
    assign Read_data_Ack  = rd_ack_r;
    assign cycle_cnt      = cyc_r;
    assign inst_cnt       = icnt_r;

endmodule

// File: tb/tb_mips_mc_cpu.sv
// Scoreboard bench for mips_mc_cpu: a latency-configurable memory responder, and a monitor that
// checks fetch addresses and store transactions against queued hand-computed expectations.
module tb_mips_mc_cpu;

    logic        clk, rst;
    logic [31:0] PC, Instruction, Address, Write_data, Read_data, cycle_cnt, inst_cnt;
    logic        Inst_Req_Valid, Inst_Req_Ack, Inst_Valid, Inst_Ack;
    logic        MemWrite, MemRead, Mem_Req_Ack, Read_data_Valid, Read_data_Ack;

    mips_mc_cpu #(.RESET_PC(32'h0000_0100), .PERF_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .PC(PC),
        .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ack(Inst_Req_Ack),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ack(Inst_Ack),
        .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead), .Write_data(Write_data),
        .Mem_Req_Ack(Mem_Req_Ack), .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
        .Read_data_Ack(Read_data_Ack), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } st_t;

    logic [31:0] exp_pc[$];
    st_t         exp_st[$];
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    int          n_tests = 0, n_fail = 0;
    int          if_lat = 0, iv_lat = 0, m_lat = 0, r_lat = 0, budget = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        imem[a[9:2]] = w;
        exp_pc.push_back(a);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0000;
    endtask

    task automatic wait_drain(input int maxc);
        int c = 0;
        while (((exp_pc.size() != 0) || (exp_st.size() != 0)) && (c < maxc)) begin
            @(negedge clk);
            c++;
        end
        check("drain_in_time", (c < maxc), 1'b1);
    endtask

    // Memory responder: handshakes observed at negedge, responses driven just after posedge
    initial begin
        logic        w_hs, f_hs;
        logic [31:0] w_a, w_d;
        int          if_w, iv_w, m_w, r_w;
        if_w = 0; iv_w = 0; m_w = 0; r_w = 0;
        Inst_Req_Ack = 1'b0; Inst_Valid = 1'b0; Instruction = 32'h0;
        Mem_Req_Ack = 1'b0; Read_data_Valid = 1'b0; Read_data = 32'h0;
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0000_0000;
        forever begin
            @(negedge clk);
            w_hs = MemWrite && Mem_Req_Ack && !rst;
            f_hs = Inst_Req_Valid && Inst_Req_Ack && !rst;
            w_a  = Address;
            w_d  = Write_data;
            @(posedge clk);
            #1;
            if (f_hs && (budget > 0)) budget--;
            if (w_hs) dmem[w_a[9:2]] = w_d;
            if (rst) begin
                if_w = 0; iv_w = 0; m_w = 0; r_w = 0;
                Inst_Req_Ack = 1'b0; Inst_Valid = 1'b0; Mem_Req_Ack = 1'b0; Read_data_Valid = 1'b0;
            end else begin
                if (Inst_Req_Valid && (budget > 0)) begin
                    Inst_Req_Ack = (if_w >= if_lat); if_w++;
                end else begin
                    Inst_Req_Ack = 1'b0; if_w = 0;
                end
                if (Inst_Ack) begin
                    Inst_Valid = (iv_w >= iv_lat); Instruction = imem[PC[9:2]]; iv_w++;
                end else begin
                    Inst_Valid = 1'b0; iv_w = 0;
                end
                if (MemWrite || MemRead) begin
                    Mem_Req_Ack = (m_w >= m_lat); m_w++;
                end else begin
                    Mem_Req_Ack = 1'b0; m_w = 0;
                end
                if (Read_data_Ack) begin
                    Read_data_Valid = (r_w >= r_lat); Read_data = dmem[Address[9:2]]; r_w++;
                end else begin
                    Read_data_Valid = 1'b0; r_w = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a fetch or store handshake completes
    initial begin
        int          wc;
        logic [31:0] fa, fd, e;
        st_t         s;
        wc = 0; fa = 32'h0; fd = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wc = 0;
            end else begin
                if (Inst_Req_Valid && Inst_Req_Ack) begin
                    if (exp_pc.size() == 0) begin
                        check("fetch_unexpected", PC, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_pc.pop_front();
                        check("fetch_pc", PC, e);
                    end
                end
                if (MemWrite) begin
                    if (wc == 0) begin fa = Address; fd = Write_data; end
                    wc++;
                    if (Mem_Req_Ack) begin
                        if (exp_st.size() == 0) begin
                            check("store_unexpected", {Address, Write_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            s = exp_st.pop_front();
                            check("store", {fa, fd, Address, Write_data, 32'(wc)},
                                  {s.addr, s.data, s.addr, s.data, 32'(s.cyc)});
                        end
                        wc = 0;
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int c;
        rst = 1'b1;

        // Program A: ALU ops, stalled store, jump, bne, undefined opcode, result stores
        clear_imem();
        if_lat = 0; iv_lat = 0; m_lat = 3; r_lat = 0;
        put(32'h100, 32'h2401_0005); put(32'h104, 32'h0021_1021); put(32'h108, 32'hAC02_0004);
        put(32'h10C, 32'h0800_0004); put(32'h010, 32'h1400_FFFF); put(32'h014, 32'hFC00_0000);
        put(32'h018, 32'h3C03_8000); put(32'h01C, 32'h3463_00F0); put(32'h020, 32'h0061_202A);
        put(32'h024, 32'h0023_282B); put(32'h028, 32'h0003_3902); put(32'h02C, 32'h0001_4023);
        put(32'h030, 32'h2909_FFFC); put(32'h034, 32'h310A_FFFF); put(32'h038, 32'hAC03_0008);
        put(32'h03C, 32'hAC04_000C); put(32'h040, 32'hAC05_0010); put(32'h044, 32'hAC07_0014);
        put(32'h048, 32'hAC08_0018); put(32'h04C, 32'hAC09_001C); put(32'h050, 32'hAC0A_0020);
        budget = exp_pc.size();
        exp_st.push_back('{32'd4,  32'd10,         4});
        exp_st.push_back('{32'd8,  32'h8000_00F0, 4});
        exp_st.push_back('{32'd12, 32'd1,          4});
        exp_st.push_back('{32'd16, 32'd1,          4});
        exp_st.push_back('{32'd20, 32'h0800_000F, 4});
        exp_st.push_back('{32'd24, 32'hFFFF_FFFB, 4});
        exp_st.push_back('{32'd28, 32'd1,          4});
        exp_st.push_back('{32'd32, 32'h0000_FFFB, 4});
        repeat (2) @(negedge clk);
        check("reset_pc", PC, 32'h100);
        check("reset_strobes", {Inst_Req_Valid, Inst_Ack, MemRead, MemWrite, Read_data_Ack}, 5'b0);
        check("reset_counters", {cycle_cnt, inst_cnt}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_fetch", {Inst_Req_Valid, PC}, {1'b1, 32'h100});
        check("cycle_cnt_1", cycle_cnt, 32'd1);
        c = 0;
        while (!MemWrite && (c < 200)) begin @(negedge clk); c++; end
        check("sw_reached", MemWrite, 1'b1);
        check("inst_cnt_before_sw", inst_cnt, 32'd2);
        wait_drain(3000);
        repeat (5) @(negedge clk);
        check("a_final", {inst_cnt, PC, Inst_Req_Valid}, {32'd21, 32'h54, 1'b1});

        // Program B: slow fetch, delayed load data, beq loop
        rst = 1'b1;
        clear_imem();
        dmem[10] = 32'h1234_5678;
        if_lat = 2; iv_lat = 1; m_lat = 0; r_lat = 5;
        put(32'h100, 32'h2401_0020); put(32'h104, 32'h8C22_0008); put(32'h108, 32'hAC02_0000);
        put(32'h10C, 32'h0800_0004); put(32'h010, 32'h1000_FFFF);
        exp_pc.push_back(32'h010); exp_pc.push_back(32'h010);
        budget = exp_pc.size();
        exp_st.push_back('{32'd0, 32'h1234_5678, 1});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c = 0;
        while (!Read_data_Ack && (c < 200)) begin @(negedge clk); c++; end
        check("rdw_reached", {Read_data_Ack, Address}, {1'b1, 32'h28});
        check("inst_cnt_in_rdw", inst_cnt, 32'd1);
        c = 0;
        while (Read_data_Ack && (c < 50)) begin c++; @(negedge clk); end
        check("rdw_cycles", c, 6);
        check("inst_cnt_after_ld", inst_cnt, 32'd2);
        wait_drain(3000);
        repeat (5) @(negedge clk);
        check("b_final", {inst_cnt, PC}, {32'd7, 32'h10});

        // Program C: reset in the middle of RDW, then show the loaded register was never written
        rst = 1'b1;
        clear_imem();
        if_lat = 0; iv_lat = 0; m_lat = 0; r_lat = 1000;
        put(32'h100, 32'h2401_0007); put(32'h104, 32'h8C01_0028);
        budget = exp_pc.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c = 0;
        while (!Read_data_Ack && (c < 200)) begin @(negedge clk); c++; end
        check("c_rdw_reached", Read_data_Ack, 1'b1);
        repeat (3) @(negedge clk);
        check("c_fetches_done", exp_pc.size(), 0);
        rst = 1'b1;
        #1;
        check("mid_reset_state", {PC, Inst_Req_Valid, Inst_Ack, MemRead, MemWrite, Read_data_Ack, inst_cnt},
              {32'h100, 5'b0, 32'd0});
        clear_imem();
        r_lat = 0;
        put(32'h100, 32'hAC01_0000);
        budget = exp_pc.size();
        exp_st.push_back('{32'd0, 32'd0, 1});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_drain(1000);
        repeat (3) @(negedge clk);
        check("c_final", {inst_cnt, PC}, {32'd1, 32'h104});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
